// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among N_REQ byte producers; start pulses one cycle after acceptance.
// Ready is offered only in IDLE, so producers stall until tx_done_in; optional burst lock under UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_BITS = 8
) (
  input  logic                         sysclk_in,
  input  logic                         nrst_in,
  input  logic [N_REQ-1:0]             req_valid_in,
  input  logic [N_REQ*DATA_BITS-1:0]   req_data_in,
  input  logic [N_REQ-1:0]             req_lock_in,
  output logic [N_REQ-1:0]             req_ready_out,
  output logic                         tx_start_out,
  output logic [DATA_BITS-1:0]         tx_data_out,
  input  logic                         tx_done_in,
  output logic                         busy_out,
  output logic [$clog2(N_REQ)-1:0]     grant_idx_out
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CW    = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] winner;
  logic             win_found;
  logic [CW-1:0]    cand;
  logic [IDX_W-1:0] sel;
  logic             sel_ok;
  logic             xfer;

  // Search starts just past the previous owner and wraps, giving rotating priority.
  always_comb begin
    winner    = last_grant;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, last_grant} + CW'(k);
      if (cand >= CW'(N_REQ)) begin
        cand = cand - CW'(N_REQ);
      end
      if (!win_found && req_valid_in[cand[IDX_W-1:0]]) begin
        winner    = cand[IDX_W-1:0];
        win_found = 1'b1;
      end
    end
  end

`ifdef UART_ARB_LOCK_EN
  logic lock_act;
  logic locked;

  // The lock owner is always last_grant, since nobody else can win while it holds.
  assign locked = lock_act & req_lock_in[last_grant];

  always_comb begin
    sel    = winner;
    sel_ok = win_found;
    if (locked) begin
      sel    = last_grant;
      sel_ok = req_valid_in[last_grant];
    end
  end

  always_ff @(posedge sysclk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      lock_act <= 1'b0;
    end else if (state == IDLE) begin
      if (xfer) begin
        lock_act <= req_lock_in[sel];
      end else if (!locked) begin
        lock_act <= 1'b0;
      end
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock_in;

  always_comb begin
    sel    = winner;
    sel_ok = win_found;
  end
`endif

  assign xfer = (state == IDLE) && sel_ok;

  always_comb begin
    req_ready_out = '0;
    if (xfer && nrst_in) begin
      req_ready_out[sel] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (xfer) state_nxt = LAUNCH;
      LAUNCH:    state_nxt = WAIT_DONE;
      WAIT_DONE: if (tx_done_in) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sysclk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      state         <= IDLE;
      last_grant    <= IDX_W'(N_REQ - 1);
      tx_start_out  <= 1'b0;
      tx_data_out   <= '0;
      busy_out      <= 1'b0;
      grant_idx_out <= '0;
    end else begin
      state        <= state_nxt;
      tx_start_out <= xfer;
      if (xfer) begin
        tx_data_out   <= req_data_in[sel*DATA_BITS +: DATA_BITS];
        last_grant    <= sel;
        grant_idx_out <= sel;
        busy_out      <= 1'b1;
      end else if (state == WAIT_DONE && tx_done_in) begin
        busy_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: rotating-priority reference model plus start-pulse monitor.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic              sysclk_in = 1'b0;
  logic              nrst_in;
  logic [N-1:0]      req_valid_in;
  logic [N*DW-1:0]   req_data_in;
  logic [N-1:0]      req_lock_in;
  logic [N-1:0]      req_ready_out;
  logic              tx_start_out;
  logic [DW-1:0]     tx_data_out;
  logic              tx_done_in;
  logic              busy_out;
  logic [1:0]        grant_idx_out;

  uart_tx_arbiter #(.N_REQ(N), .DATA_BITS(DW)) dut (
    .sysclk_in     (sysclk_in),
    .nrst_in       (nrst_in),
    .req_valid_in  (req_valid_in),
    .req_data_in   (req_data_in),
    .req_lock_in   (req_lock_in),
    .req_ready_out (req_ready_out),
    .tx_start_out  (tx_start_out),
    .tx_data_out   (tx_data_out),
    .tx_done_in    (tx_done_in),
    .busy_out      (busy_out),
    .grant_idx_out (grant_idx_out)
  );

  always #5 sysclk_in = ~sysclk_in;

  typedef struct {
    logic [7:0] d;
    int         idx;
  } exp_t;

  exp_t       exp_q[$];
  int         obs_idx[$];
  int         total = 0;
  int         bad   = 0;

  bit         m_busy;
  int         m_age;
  int         m_last;
  int         m_gidx;
  logic [7:0] m_data;
  bit         m_lock;
  int         n_xfer = 0;
  int         n_to1  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_age  = 0;
    m_last = N - 1;
    m_gidx = 0;
    m_data = '0;
    m_lock = 0;
    exp_q.delete();
  endtask

  // One clock: check registered state, drive inputs, predict the coming edge, check ready.
  task automatic step(input logic [3:0] v, input logic [31:0] d, input logic [3:0] lk, input logic dn);
    int         w;
    logic [3:0] er;
    bit         locked;
    chk("busy", 32'(busy_out), 32'(m_busy));
    chk("grant_idx", 32'(grant_idx_out), 32'(m_gidx));
    chk("tx_data", 32'(tx_data_out), 32'(m_data));
    req_valid_in = v;
    req_data_in  = d;
    req_lock_in  = lk;
    tx_done_in   = dn;
    er = '0;
    w  = -1;
    if (!m_busy) begin
      locked = 0;
`ifdef UART_ARB_LOCK_EN
      locked = m_lock && lk[m_last];
`endif
      if (locked) begin
        if (v[m_last]) w = m_last;
      end else begin
        for (int k = 1; k <= N; k++) begin
          if (w < 0 && v[(m_last + k) % N]) w = (m_last + k) % N;
        end
      end
      if (w >= 0) begin
        er[w] = 1'b1;
        exp_q.push_back('{d[w*8 +: 8], w});
        m_busy = 1;
        m_age  = 1;
        m_last = w;
        m_gidx = w;
        m_data = d[w*8 +: 8];
        n_xfer++;
        if (w == 1) n_to1++;
        m_lock = lk[w];
      end else if (!locked) begin
        m_lock = 0;
      end
    end else begin
      if (m_age >= 2 && dn) m_busy = 0;
      m_age++;
    end
    #1;
    chk("ready", 32'(req_ready_out), 32'(er));
    @(posedge sysclk_in);
    @(negedge sysclk_in);
  endtask

  task automatic run(input logic [3:0] v, input logic [31:0] d, input logic [3:0] lk, input int n);
    for (int i = 0; i < n; i++) step(v, d, lk, m_busy && m_age >= 3);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_start"}, 32'(tx_start_out), 32'd0);
    chk({tag, "_data"}, 32'(tx_data_out), 32'd0);
    chk({tag, "_busy"}, 32'(busy_out), 32'd0);
    chk({tag, "_grant"}, 32'(grant_idx_out), 32'd0);
    chk({tag, "_ready"}, 32'(req_ready_out), 32'd0);
  endtask

  // Monitor: every start pulse must match the oldest predicted grant.
  initial begin
    exp_t e;
    forever begin
      @(negedge sysclk_in);
      if (tx_start_out === 1'b1) begin
        obs_idx.push_back(int'(grant_idx_out));
        if (exp_q.size() == 0) begin
          chk("start_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("start_data", 32'(tx_data_out), 32'(e.d));
          chk("start_idx", 32'(grant_idx_out), 32'(e.idx));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    int base1;
    int exp_lock[5];
    nrst_in      = 1'b0;
    req_valid_in = 4'hF;
    req_data_in  = '0;
    req_lock_in  = '0;
    tx_done_in   = 1'b0;
    model_reset();
    @(negedge sysclk_in);
    @(negedge sysclk_in);
    check_reset_outputs("por");
    nrst_in      = 1'b1;
    req_valid_in = '0;

    // Single request from requester 2.
    obs_idx.delete();
    step(4'b0100, 32'h00A5_0000, 4'b0000, 1'b0);
    step(4'b0000, 32'h0, 4'b0000, 1'b0);
    run(4'b0000, 32'h0, 4'b0000, 6);
    chk("single_cnt", 32'(obs_idx.size()), 32'd1);

    // Spurious done in IDLE and in the LAUNCH cycle.
    step(4'b0000, 32'h0, 4'b0000, 1'b1);
    step(4'b0000, 32'h0, 4'b0000, 1'b1);
    step(4'b0001, 32'h0000_005C, 4'b0000, 1'b0);
    step(4'b0000, 32'h0, 4'b0000, 1'b1);
    step(4'b0000, 32'h0, 4'b0000, 1'b0);
    run(4'b0000, 32'h0, 4'b0000, 6);

    // Reset while waiting for done.
    step(4'b0010, 32'h0000_7700, 4'b0000, 1'b0);
    step(4'b0000, 32'h0, 4'b0000, 1'b0);
    step(4'b0000, 32'h0, 4'b0000, 1'b0);
    req_valid_in = 4'hF;
    nrst_in = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(posedge sysclk_in);
    @(negedge sysclk_in);
    check_reset_outputs("midrst_hold");
    nrst_in = 1'b1;

    // Fairness: all four valid for eight frames.
    obs_idx.delete();
    base = n_xfer;
    for (int i = 0; i < 300 && (n_xfer - base) < 8; i++) step(4'hF, 32'h1312_1110, 4'b0000, m_busy && m_age >= 3);
    run(4'b0000, 32'h0, 4'b0000, 6);
    chk("rr_cnt", 32'(obs_idx.size()), 32'd8);
    for (int i = 0; i < obs_idx.size() && i < 8; i++) chk("rr_seq", 32'(obs_idx[i]), 32'(i % 4));

    // Lock scenario: requester 1 holds 3 bytes while 0 and 3 are waiting.
    run(4'b0001, 32'h0000_0099, 4'b0000, 1);
    run(4'b0000, 32'h0, 4'b0000, 6);
    obs_idx.delete();
    base  = n_xfer;
    base1 = n_to1;
    for (int i = 0; i < 300 && (n_xfer - base) < 5; i++) begin
      logic one_left;
      one_left = (n_to1 - base1) < 3;
      run({1'b1, 1'b0, one_left, 1'b1}, 32'h3322_1100, {2'b00, one_left, 1'b0}, 1);
    end
    run(4'b0000, 32'h0, 4'b0000, 6);
`ifdef UART_ARB_LOCK_EN
    exp_lock = '{1, 1, 1, 3, 0};
`else
    exp_lock = '{1, 3, 0, 1, 3};
`endif
    chk("lock_cnt", 32'(obs_idx.size()), 32'd5);
    for (int i = 0; i < obs_idx.size() && i < 5; i++) chk("lock_seq", 32'(obs_idx[i]), 32'(exp_lock[i]));

    // Random traffic with random done timing and spurious done pulses.
    for (int i = 0; i < 1500; i++) begin
      step(4'($urandom), $urandom, 4'($urandom_range(0, 15) < 3 ? $urandom : 0), ($urandom % 3) == 0);
    end
    run(4'b0000, 32'h0, 4'b0000, 8);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares a single UART transmitter among N_REQ byte producers. Each requester offers a byte with a valid/ready handshake. The arbiter latches the winning byte, pulses the transmitter's start input, and holds ownership until the transmitter reports completion. It sits between on-chip producers (command responder, debug/log, status) and the shared `uart_tx`, in the same `sysclk_in` domain as the baud generator.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DATA_BITS, 8, byte width; must match the transmitter's DATA_BITS
- sysclk_in  in  1  system clock; all logic on rising edge
- nrst_in  in  1  asynchronous, active-low reset
- req_valid_in  in  N_REQ  bit i: requester i offers req_data_in slice i
- req_data_in  in  N_REQ*DATA_BITS  requester i data at bits [i*DATA_BITS +: DATA_BITS]
- req_lock_in  in  N_REQ  bit i: requester i requests burst lock; used only with UART_ARB_LOCK_EN
- req_ready_out  out  N_REQ  one-hot or zero; a transfer occurs when valid[i] and ready[i] are both high on a clock edge
- tx_start_out  out  1  one-cycle start pulse to the transmitter
- tx_data_out  out  DATA_BITS  registered byte; stable from the start pulse until done
- tx_done_in  in  1  one-cycle pulse from the transmitter after the stop bit
- busy_out  out  1  high from acceptance until done is consumed
- grant_idx_out  out  $clog2(N_REQ)  index of the current or last owner

## Operation
- Clock and reset: single clock, `sysclk_in`. Reset `nrst_in` is asynchronous and active-low.
- States: IDLE, LAUNCH, WAIT_DONE.
- IDLE:
  - Combinational winner = first i with req_valid_in[i], searching from (last_grant+1) mod N_REQ upward with wrap.
  - req_ready_out[winner] = 1. All other ready bits are 0.
  - On the transfer edge: latch tx_data_out, set last_grant = winner, set grant_idx_out = winner, set busy_out = 1, go to LAUNCH.
  - With no valid requester, stay in IDLE with ready all 0.
- LAUNCH: tx_start_out = 1 for exactly this cycle, then go to WAIT_DONE.
- WAIT_DONE:
  - Stay until tx_done_in = 1.
  - On done: go to IDLE and clear busy_out on the same edge.
- req_ready_out is 0 in LAUNCH and WAIT_DONE. Requester valid changes in those states have no effect.
- A requester may drop valid before it is accepted; no transfer occurs and no state changes.
- tx_done_in outside WAIT_DONE is ignored. tx_done_in in the same cycle as the LAUNCH start pulse is ignored.
- Round-robin fairness: with all N_REQ requesters valid continuously, grants go 0,1,..,N_REQ-1,0,…

## Timing
- Reset values:
  - state = IDLE
  - req_ready_out = 0 while nrst_in is low
  - tx_start_out = 0
  - tx_data_out = 0
  - busy_out = 0
  - grant_idx_out = 0
  - last_grant = N_REQ-1, so requester 0 has first priority
- Reset mid-operation:
  - All registers return to reset values immediately.
  - A pending start pulse is suppressed.
  - The in-flight byte is discarded; the transmitter is reset by the same nrst_in.
- Latency:
  - Transfer edge T → tx_start_out high in cycle T+1.
  - tx_done_in sampled at edge D → IDLE at D+1. The earliest next transfer is edge D+1.
- Per-byte overhead beyond the transmitter frame: 2 cycles.
- req_ready_out is combinational from req_valid_in and state. tx_start_out, tx_data_out, busy_out and grant_idx_out are registered.

## Configuration
- UART_ARB_LOCK_EN defined:
  - A requester that wins while req_lock_in[i] = 1 becomes lock owner.
  - While the owner's req_lock_in stays high, IDLE grants only the owner, even if its valid is low; others wait.
  - Lock is released when the owner's req_lock_in is sampled low in IDLE, or at reset.
  - On release, round-robin resumes from owner+1.
- UART_ARB_LOCK_EN undefined: req_lock_in is ignored (port kept for a stable interface) and arbitration is pure round-robin.

## Test plan
- Reset then single request:
  - Stimulus: valid[2]=1, data 0xA5.
  - Required: ready[2] one cycle; tx_start_out next cycle with tx_data_out=0xA5; busy_out=1 until tx_done_in, then 0 one cycle later.
- All four valid continuously with distinct bytes 0x10..0x13 for 8 frames:
  - Required: tx_data_out order 0x10,0x11,0x12,0x13,0x10,…
  - Required: grant_idx_out sequence 0,1,2,3,0,….
- tx_done_in pulsed during IDLE and in the LAUNCH cycle:
  - Required: ignored; no state change; busy_out stays as before.
- nrst_in low during WAIT_DONE:
  - Required: all outputs at reset values immediately.
  - Required: after release, with valid[0..3]=1, requester 0 is granted first.
- UART_ARB_LOCK_EN with lock[1]=1 for 3 bytes while valid[0]=valid[3]=1:
  - Required: three consecutive grants to 1, then 3, then 0.
- Same sequence as the previous test with the macro undefined:
  - Required: grants 1,3,0 and lock ignored.
